// File: rtl/if_id_buffer.sv
// Two-entry in-order skid buffer between fetch and decode.
// Fetch enable (ready_f) depends only on occupancy, so decode hazards never reach the PC register.
module if_id_buffer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr_f,
    input  logic [WIDTH-1:0] pc_plus_4_f,
    input  logic             valid_f,
    output logic             ready_f,
    input  logic             stall_d,
    input  logic             flush_d,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_plus_4_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] stall_count
);

    // state   | meaning
    // S_EMPTY | no entry; decode sees NOP bubble
    // S_ONE   | slot0 holds the head instruction
    // S_FULL  | slot0 head, slot1 tail; fetch is held off
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    occ_t             r_state;
    occ_t             w_state_nxt;
    logic [WIDTH-1:0] r_s0_instr, r_s0_pc, r_s1_instr, r_s1_pc;
    logic [WIDTH-1:0] w_s0_instr_nxt, w_s0_pc_nxt, w_s1_instr_nxt, w_s1_pc_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_push;
    logic             w_pop;
    logic             w_stall_inc;

    assign valid_d     = (r_state != S_EMPTY);
    assign ready_f     = (r_state != S_FULL);
    assign instr_d     = valid_d ? r_s0_instr : NOP_INSTR;
    assign pc_plus_4_d = valid_d ? r_s0_pc : '0;
    assign stall_count = r_stall_cnt;

    assign w_push      = valid_f & ready_f;
    assign w_pop       = valid_d & ~stall_d;
    assign w_stall_inc = valid_d & stall_d & ~flush_d & ~(&r_stall_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_s0_instr <= '0;
            r_s0_pc    <= '0;
            r_s1_instr <= '0;
            r_s1_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s0_instr <= w_s0_instr_nxt;
            r_s0_pc    <= w_s0_pc_nxt;
            r_s1_instr <= w_s1_instr_nxt;
            r_s1_pc    <= w_s1_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_s0_instr_nxt = r_s0_instr;
        w_s0_pc_nxt    = r_s0_pc;
        w_s1_instr_nxt = r_s1_instr;
        w_s1_pc_nxt    = r_s1_pc;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_s0_instr_nxt = instr_f;
                    w_s0_pc_nxt    = pc_plus_4_f;
                    w_state_nxt    = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_s1_instr_nxt = instr_f;
                    w_s1_pc_nxt    = pc_plus_4_f;
                    w_state_nxt    = S_FULL;
                end else if (w_push && w_pop) begin
                    w_s0_instr_nxt = instr_f;
                    w_s0_pc_nxt    = pc_plus_4_f;
                end else if (w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_s0_instr_nxt = r_s1_instr;
                    w_s0_pc_nxt    = r_s1_pc;
                    w_state_nxt    = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Slot data may be left stale on flush; occupancy alone hides it.
        if (flush_d) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue-based reference model checked every cycle, plus directed literal checks.
// A second instance with a 4-bit stall counter exercises saturation.
module tb_if_id_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] instr_f;
    logic [31:0] pc_plus_4_f;
    logic        valid_f;
    logic        stall_d;
    logic        flush_d;

    logic        ready_f,  ready_f4;
    logic [31:0] instr_d,  instr_d4;
    logic [31:0] pc_d,     pc_d4;
    logic        valid_d,  valid_d4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 0;

    if_id_buffer #(.WIDTH(32), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_plus_4_f(pc_plus_4_f),
        .valid_f(valid_f), .ready_f(ready_f), .stall_d(stall_d), .flush_d(flush_d),
        .instr_d(instr_d), .pc_plus_4_d(pc_d), .valid_d(valid_d), .stall_count(stall_count)
    );

    if_id_buffer #(.WIDTH(32), .NOP_INSTR(32'h0000_0000), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_plus_4_f(pc_plus_4_f),
        .valid_f(valid_f), .ready_f(ready_f4), .stall_d(stall_d), .flush_d(flush_d),
        .instr_d(instr_d4), .pc_plus_4_d(pc_d4), .valid_d(valid_d4), .stall_count(stall_count4)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO of {instr, pc} with at most two entries.
    logic [63:0] mq[$];
    int          m_cnt16 = 0;
    int          m_cnt4  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_cnt16 = 0;
            m_cnt4  = 0;
        end else begin
            automatic bit do_push = valid_f && (mq.size() < 2);
            automatic bit do_pop  = (mq.size() > 0) && !stall_d;
            if ((mq.size() > 0) && stall_d && !flush_d) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush_d) mq.delete();
            else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back({instr_f, pc_plus_4_f});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic logic [31:0] e_i = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
            automatic logic [31:0] e_p = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
            chk("model valid_d", {63'b0, valid_d}, {63'b0, mq.size() > 0});
            chk("model ready_f", {63'b0, ready_f}, {63'b0, mq.size() != 2});
            chk("model instr_d", {32'b0, instr_d}, {32'b0, e_i});
            chk("model pc_d",    {32'b0, pc_d},    {32'b0, e_p});
            chk("model stall16", {48'b0, stall_count}, 64'(m_cnt16));
            chk("model valid_d4", {63'b0, valid_d4}, {63'b0, mq.size() > 0});
            chk("model instr_d4", {32'b0, instr_d4}, {32'b0, e_i});
            chk("model stall4",  {60'b0, stall_count4}, 64'(m_cnt4));
        end
    end

    task automatic set_in(input bit v, input logic [31:0] i, input logic [31:0] p,
                          input bit s, input bit f);
        valid_f = v; instr_f = i; pc_plus_4_f = p; stall_d = s; flush_d = f;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1;
        set_in(0, 32'h0, 32'h0, 0, 0);
        #1;
        chk("reset valid_d", {63'b0, valid_d}, 64'd0);
        chk("reset ready_f", {63'b0, ready_f}, 64'd1);
        chk("reset instr_d", {32'b0, instr_d}, 64'h0);
        chk("reset stall",   {48'b0, stall_count}, 64'd0);
        repeat (2) step();
        reset = 0;
        cmp_en = 1;

        // Streaming
        set_in(1, 32'h2008_0001, 32'h4, 0, 0); step();
        chk("stream A", {32'b0, instr_d}, 64'h2008_0001);
        chk("stream A pc", {32'b0, pc_d}, 64'h4);
        set_in(1, 32'h2009_0002, 32'h8, 0, 0); step();
        chk("stream B", {32'b0, instr_d}, 64'h2009_0002);
        chk("stream ready", {63'b0, ready_f}, 64'd1);
        set_in(1, 32'h200A_0003, 32'hC, 0, 0); step();
        chk("stream C", {32'b0, instr_d}, 64'h200A_0003);
        chk("stream C pc", {32'b0, pc_d}, 64'hC);
        set_in(0, 32'h0, 32'h0, 0, 0); step();
        chk("stream drain", {63'b0, valid_d}, 64'd0);
        chk("stream stall", {48'b0, stall_count}, 64'd0);

        // Fill / backpressure
        set_in(1, 32'h0000_0A0A, 32'h10, 1, 0); step();
        set_in(1, 32'h0000_0B0B, 32'h14, 1, 0); step();
        chk("full ready", {63'b0, ready_f}, 64'd0);
        set_in(1, 32'h0000_0C0C, 32'h18, 1, 0); step(); step();
        chk("full head A", {32'b0, instr_d}, 64'h0A0A);
        chk("full ready held", {63'b0, ready_f}, 64'd0);
        chk("full stall cnt", {48'b0, stall_count}, 64'd3);
        set_in(1, 32'h0000_0C0C, 32'h18, 0, 0); step();
        chk("drain B", {32'b0, instr_d}, 64'h0B0B);
        step();
        chk("pushpop C", {32'b0, instr_d}, 64'h0C0C);
        chk("pushpop ready", {63'b0, ready_f}, 64'd1);
        set_in(0, 32'h0, 32'h0, 0, 0); step();
        chk("drain empty", {63'b0, valid_d}, 64'd0);

        // Flush at full with stall
        set_in(1, 32'h0000_1111, 32'h20, 1, 0); step();
        set_in(1, 32'h0000_2222, 32'h24, 1, 0); step();
        set_in(1, 32'h0000_3333, 32'h28, 1, 1); step();
        chk("flush valid", {63'b0, valid_d}, 64'd0);
        chk("flush instr", {32'b0, instr_d}, 64'h0);
        chk("flush pc",    {32'b0, pc_d}, 64'h0);
        chk("flush ready", {63'b0, ready_f}, 64'd1);
        chk("flush stall", {48'b0, stall_count}, 64'd4);
        set_in(0, 32'h0, 32'h0, 0, 0); step();
        chk("flush D gone", {63'b0, valid_d}, 64'd0);

        // Saturation
        set_in(1, 32'h0000_4444, 32'h30, 1, 0); step();
        set_in(0, 32'h0, 32'h0, 1, 0);
        repeat (20) step();
        chk("sat cnt4", {60'b0, stall_count4}, 64'd15);
        chk("sat cnt16", {48'b0, stall_count}, 64'd24);

        // Async reset at full occupancy
        set_in(1, 32'h0000_5555, 32'h34, 1, 0); step();
        set_in(0, 32'h0, 32'h0, 1, 0);
        chk("pre-reset full", {63'b0, ready_f}, 64'd0);
        #1 reset = 1;
        #1;
        chk("areset valid", {63'b0, valid_d}, 64'd0);
        chk("areset instr", {32'b0, instr_d}, 64'h0);
        chk("areset pc",    {32'b0, pc_d}, 64'h0);
        chk("areset ready", {63'b0, ready_f}, 64'd1);
        chk("areset stall", {48'b0, stall_count}, 64'd0);
        #1 reset = 0;
        set_in(1, 32'h2008_0001, 32'h4, 0, 0); step();
        chk("resume A", {32'b0, instr_d}, 64'h2008_0001);
        set_in(1, 32'h2009_0002, 32'h8, 0, 0); step();
        chk("resume B", {32'b0, instr_d}, 64'h2009_0002);
        set_in(0, 32'h0, 32'h0, 0, 0); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Two-entry in-order skid buffer between the fetch stage (instr, pc_plus_4) and the decode stage.
- Replaces a plain IF/ID enable register. Decouples the fetch stall (ready_f, wired to the fetch enable) from the decode stall, so there is no combinational path from decode hazards to the PC register.
- Supports branch flush, inserts NOP bubbles when empty, and counts decode-stall cycles for performance debug.

Parameters:
- WIDTH, 32, width of the instruction and PC+4 fields.
- NOP_INSTR, 32'h0000_0000, instruction presented to decode when no valid entry exists (MIPS sll $0,$0,0).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- instr_f  input  WIDTH  instruction from fetch.
- pc_plus_4_f  input  WIDTH  PC+4 from fetch.
- valid_f  input  1  fetch presents a valid instruction this cycle.
- ready_f  output  1  buffer can accept; drives the fetch enable (not stallF).
- stall_d  input  1  decode cannot consume this cycle (from hazard unit).
- flush_d  input  1  discard all buffered and incoming instructions (taken branch/jump).
- instr_d  output  WIDTH  instruction to decode.
- pc_plus_4_d  output  WIDTH  PC+4 to decode.
- valid_d  output  1  instr_d/pc_plus_4_d hold a real instruction.
- stall_count  output  CNT_W  saturating count of cycles with valid_d=1 and stall_d=1.

Behaviour:
- State: slot0 (head) and slot1 (tail), each holding {instr, pc_plus_4}; count register in 0..2.
- Outputs come from registers only:
  - instr_d = slot0.instr and pc_plus_4_d = slot0.pc_plus_4 when count>0; otherwise NOP_INSTR and 0.
  - valid_d = (count!=0).
  - ready_f = (count!=2).
  - No combinational path from stall_d, flush_d or valid_f to any output.
- push = valid_f & ready_f; pop = valid_d & ~stall_d; both are evaluated on the same edge.
- Transitions (flush_d=0):
  - count0: push -> slot0<=in, count1.
  - count1: push&~pop -> slot1<=in, count2. push&pop -> slot0<=in, count1. ~push&pop -> count0. Neither -> hold.
  - count2: pop -> slot0<=slot1, count1 (push impossible since ready_f=0). No pop -> hold.
- Ordering: strictly FIFO. An instruction accepted at edge N is visible on instr_d at the earliest after edge N (1-cycle latency).
- flush_d=1:
  - count<=0 next edge, regardless of stall_d, push or pop; the incoming instruction that cycle is discarded.
  - Slot contents need not be cleared, but outputs show NOP_INSTR/0 because count=0.
  - Flush dominates all other events.
- stall_count:
  - Increments on each edge where valid_d & stall_d & ~flush_d.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- Reset (asynchronous, any time including mid-transfer):
  - count=0, valid_d=0, instr_d=NOP_INSTR, pc_plus_4_d=0, ready_f=1, stall_count=0.
  - Slot data reset to 0.
  - The first push is accepted on the first rising edge after reset deassertion.
- Throughput: with stall_d=0 continuously, one instruction per cycle and ready_f stays 1.
- Boundary condition: valid_f=0 with ready_f=1 is legal (fetch bubble); no entry is created.

Test Plan:
- Streaming: reset, then valid_f=1 with instr_f=0x20080001, 0x20090002, 0x200A0003 (pc_plus_4 0x4, 0x8, 0xC), stall_d=0 -> instr_d shows the same sequence one cycle later, valid_d=1, ready_f stays 1, stall_count=0.
- Fill/backpressure: push A, B with stall_d=1 -> count2, ready_f=0 the cycle after B and held; a third valid_f is not accepted. Release stall_d -> A, B, C emerge in order, no loss or duplication; stall_count equals the stalled valid cycles (e.g. 3).
- Simultaneous push+pop at count1: hold one entry, then present C with stall_d=0 -> next cycle instr_d=C, valid_d=1, ready_f=1.
- Flush: at count2 with stall_d=1, assert flush_d with valid_f=1 for D -> next cycle valid_d=0, instr_d=0x00000000, pc_plus_4_d=0, ready_f=1, D discarded, stall_count not incremented that edge.
- Saturation with CNT_W=4: hold valid_d=1 and stall_d=1 for 20 cycles -> stall_count reaches 15 and stays 15.
- Async reset mid-operation: at count2, pulse reset between clock edges -> outputs go immediately to NOP_INSTR, 0, valid_d=0, ready_f=1, stall_count=0; normal streaming resumes after deassertion.
